// File: rtl/bcd_frame_loader_if.sv
// Digit-stream input and frame output bundle for bcd_frame_loader.
// The slave modport is the loader's view; the master modport is the view of whatever drives it.
interface bcd_frame_loader_if;
  logic [3:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        mode_in;
  logic        clear;
  logic [15:0] a;
  logic        div_11_n3;
  logic        frame_valid;
  logic        frame_ready;
  logic [1:0]  rem3;
  logic [3:0]  rem11;
  logic        pred;
  logic        err;

  modport master (
    output din, din_valid, mode_in, clear, frame_ready,
    input  din_ready, a, div_11_n3, frame_valid, rem3, rem11, pred, err
  );

  modport slave (
    input  din, din_valid, mode_in, clear, frame_ready,
    output din_ready, a, div_11_n3, frame_valid, rem3, rem11, pred, err
  );
endinterface

// File: rtl/bcd_frame_loader.sv
// Assembles four BCD digits (MSD first) into a 16-bit frame, with running mod-3 / mod-11
// remainders and a predicted divisibility result for cross-checking the downstream checker.
module bcd_frame_loader #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic              clk,
  input logic              rst,
  bcd_frame_loader_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  count_reg, count_next;
  logic [11:0] shift_reg, shift_next;
  logic [1:0]  r3_reg, r3_next;
  logic [3:0]  r11_reg, r11_next;
  logic        mode_reg, mode_next;
  logic [7:0]  idle_reg, idle_next;

  logic [15:0] a_reg, a_next;
  logic        div_reg, div_next;
  logic        fv_reg, fv_next;
  logic [1:0]  rem3_reg, rem3_next;
  logic [3:0]  rem11_reg, rem11_next;
  logic        pred_reg, pred_next;
  logic        err_reg, err_next;

  logic        ready;
  logic        xfer;
  logic        invalid;
  logic        timeout_hit;
  logic [1:0]  r3_base;
  logic [3:0]  r11_base;
  logic [4:0]  sum3;
  logic [4:0] sum3_red;
  logic [4:0]  diff11;
  logic [4:0]  diff11_red;
  logic [1:0]  r3_step;
  logic [3:0]  r11_step;

  assign ready   = ~rst & ~bus.clear & (state_reg != ST_FULL);
  assign xfer    = bus.din_valid & ready;
  assign invalid = xfer & (bus.din > 4'd9);

  // Counter holds the number of idle edges already seen since the last transfer.
  assign timeout_hit = (TIMEOUT != 8'd0) && (state_reg == ST_COLLECT) && !xfer &&
                       (idle_reg == TIMEOUT - 8'd1);

  // Remainder step for the digit on din; the first digit of a frame starts from zero.
  always_comb begin
    r3_base  = (state_reg == ST_IDLE) ? 2'd0 : r3_reg;
    r11_base = (state_reg == ST_IDLE) ? 4'd0 : r11_reg;

    sum3 = {3'b000, r3_base} + {1'b0, bus.din};
    if (sum3 >= 5'd9)
      sum3_red = sum3 - 5'd9;
    else if (sum3 >= 5'd6)
      sum3_red = sum3 - 5'd6;
    else if (sum3 >= 5'd3)
      sum3_red = sum3 - 5'd3;
    else
      sum3_red = sum3;
    r3_step = sum3_red[1:0];

    // 10 == -1 (mod 11), so appending a digit negates the old remainder.
    diff11 = {1'b0, bus.din} + 5'd11 - {1'b0, r11_base};
    if (diff11 >= 5'd11)
      diff11_red = diff11 - 5'd11;
    else
      diff11_red = diff11;
    r11_step = diff11_red[3:0];
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shift_next = shift_reg;
    r3_next    = r3_reg;
    r11_next   = r11_reg;
    mode_next  = mode_reg;
    idle_next  = 8'd0;
    a_next     = a_reg;
    div_next   = div_reg;
    fv_next    = fv_reg;
    rem3_next  = rem3_reg;
    rem11_next = rem11_reg;
    pred_next  = pred_reg;
    err_next   = 1'b0;

    if (bus.clear) begin
      state_next = ST_IDLE;
      count_next = 2'd0;
      fv_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_COLLECT: begin
          if (xfer) begin
            if (invalid) begin
              state_next = ST_IDLE;
              count_next = 2'd0;
              err_next   = 1'b1;
            end else if (count_reg == 2'd3) begin
              state_next = ST_FULL;
              count_next = 2'd0;
              a_next     = {shift_reg, bus.din};
              div_next   = mode_reg;
              fv_next    = 1'b1;
              rem3_next  = r3_step;
              rem11_next = r11_step;
              pred_next  = mode_reg ? (r11_step == 4'd0) : (r3_step == 2'd0);
            end else begin
              state_next = ST_COLLECT;
              count_next = count_reg + 2'd1;
              shift_next = {shift_reg[7:0], bus.din};
              r3_next    = r3_step;
              r11_next   = r11_step;
              if (state_reg == ST_IDLE)
                mode_next = bus.mode_in;
            end
          end else if (timeout_hit) begin
            state_next = ST_IDLE;
            count_next = 2'd0;
            err_next   = 1'b1;
          end else if (state_reg == ST_COLLECT && TIMEOUT != 8'd0) begin
            idle_next = idle_reg + 8'd1;
          end
        end
        ST_FULL: begin
          if (bus.frame_ready) begin
            state_next = ST_IDLE;
            fv_next    = 1'b0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          count_next = 2'd0;
          fv_next    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      count_reg <= 2'd0;
      shift_reg <= 12'd0;
      r3_reg    <= 2'd0;
      r11_reg   <= 4'd0;
      mode_reg  <= 1'b0;
      idle_reg  <= 8'd0;
      a_reg     <= 16'd0;
      div_reg   <= 1'b0;
      fv_reg    <= 1'b0;
      rem3_reg  <= 2'd0;
      rem11_reg <= 4'd0;
      pred_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
      r3_reg    <= r3_next;
      r11_reg   <= r11_next;
      mode_reg  <= mode_next;
      idle_reg  <= idle_next;
      a_reg     <= a_next;
      div_reg   <= div_next;
      fv_reg    <= fv_next;
      rem3_reg  <= rem3_next;
      rem11_reg <= rem11_next;
      pred_reg  <= pred_next;
      err_reg   <= err_next;
    end
  end

  assign bus.din_ready   = ready;
  assign bus.a           = a_reg;
  assign bus.div_11_n3   = div_reg;
  assign bus.frame_valid = fv_reg;
  assign bus.rem3        = rem3_reg;
  assign bus.rem11       = rem11_reg;
  assign bus.pred        = pred_reg;
  assign bus.err         = err_reg;

endmodule

// File: tb/tb_bcd_frame_loader.sv
// Directed bench for bcd_frame_loader: frame assembly, remainders, backpressure and aborts.
module tb_bcd_frame_loader;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_frame_loader_if bus ();

  bcd_frame_loader #(.TIMEOUT(8'd8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one digit; returns 1 time unit after the accepting edge.
  task automatic drive_digit(input logic [3:0] d, input logic m);
    bus.din       = d;
    bus.mode_in   = m;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [15:0] f, input logic m);
    drive_digit(f[15:12], m);
    drive_digit(f[11:8], m);
    drive_digit(f[7:4], m);
    drive_digit(f[3:0], m);
    $display("frame a=%h div_11_n3=%0d rem3=%0d rem11=%0d pred=%0d", bus.a, bus.div_11_n3, bus.rem3, bus.rem11, bus.pred);
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.din_ready !== 1'b0) begin bad++; $display("FAIL rst_din_ready got=%b exp=0", bus.din_ready); end
    total++; if (bus.a !== 16'h0000) begin bad++; $display("FAIL rst_a got=%h exp=0000", bus.a); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b exp=0", bus.frame_valid); end
    total++; if (bus.err !== 1'b0 || bus.pred !== 1'b0) begin bad++; $display("FAIL rst_err_pred got=%b%b exp=00", bus.err, bus.pred); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (bus.din_ready !== 1'b1) begin bad++; $display("FAIL rel_din_ready got=%b exp=1", bus.din_ready); end
  endtask

  task automatic test_back_to_back();
    bus.frame_ready = 1'b1;
    drive_digit(4'd3, 1'b0);
    drive_digit(4'd2, 1'b0);
    drive_digit(4'd3, 1'b0);
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_fv got=%b exp=0", bus.frame_valid); end
    drive_digit(4'd4, 1'b0);
    $display("frame a=%h rem3=%0d rem11=%0d pred=%0d", bus.a, bus.rem3, bus.rem11, bus.pred);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_fv got=%b exp=1", bus.frame_valid); end
    total++; if (bus.a !== 16'h3234) begin bad++; $display("FAIL b2b_a got=%h exp=3234", bus.a); end
    total++; if (bus.div_11_n3 !== 1'b0) begin bad++; $display("FAIL b2b_mode got=%b exp=0", bus.div_11_n3); end
    total++; if (bus.rem3 !== 2'd0 || bus.rem11 !== 4'd0) begin bad++; $display("FAIL b2b_rem got=%0d/%0d exp=0/0", bus.rem3, bus.rem11); end
    total++; if (bus.pred !== 1'b1) begin bad++; $display("FAIL b2b_pred got=%b exp=1", bus.pred); end
    total++; if (bus.din_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b exp=0", bus.din_ready); end
    @(posedge clk);
    #1;
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL b2b_fv_one_cycle got=%b exp=0", bus.frame_valid); end
  endtask

  task automatic test_remainders();
    drive_frame(16'h3235, 1'b1);
    total++; if (bus.a !== 16'h3235 || bus.div_11_n3 !== 1'b1) begin bad++; $display("FAIL m11_frame got=%h/%b exp=3235/1", bus.a, bus.div_11_n3); end
    total++; if (bus.rem11 !== 4'd1 || bus.pred !== 1'b0) begin bad++; $display("FAIL m11_rem got=%0d/%b exp=1/0", bus.rem11, bus.pred); end
    @(posedge clk); #1;
    drive_frame(16'h9899, 1'b0);
    total++; if (bus.a !== 16'h9899 || bus.div_11_n3 !== 1'b0) begin bad++; $display("FAIL m3_frame got=%h/%b exp=9899/0", bus.a, bus.div_11_n3); end
    total++; if (bus.rem3 !== 2'd2 || bus.rem11 !== 4'd10) begin bad++; $display("FAIL m3_rem got=%0d/%0d exp=2/10", bus.rem3, bus.rem11); end
    total++; if (bus.pred !== 1'b0) begin bad++; $display("FAIL m3_pred got=%b exp=0", bus.pred); end
    @(posedge clk); #1;
    drive_frame(16'h9999, 1'b0);
    total++; if (bus.pred !== 1'b1 || bus.rem3 !== 2'd0) begin bad++; $display("FAIL n9999_m3 got=%b/%0d exp=1/0", bus.pred, bus.rem3); end
    @(posedge clk); #1;
    drive_frame(16'h9999, 1'b1);
    total++; if (bus.pred !== 1'b1 || bus.rem11 !== 4'd0) begin bad++; $display("FAIL n9999_m11 got=%b/%0d exp=1/0", bus.pred, bus.rem11); end
    @(posedge clk); #1;
    drive_frame(16'h0000, 1'b1);
    total++; if (bus.pred !== 1'b1 || bus.a !== 16'h0000) begin bad++; $display("FAIL n0000 got=%b/%h exp=1/0000", bus.pred, bus.a); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.frame_ready = 1'b0;
    drive_frame(16'h8558, 1'b0);
    bus.din       = 4'd7;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++; if (bus.frame_valid !== 1'b1 || bus.a !== 16'h8558) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/8558", i, bus.frame_valid, bus.a); end
      total++; if (bus.din_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, bus.din_ready); end
      @(posedge clk); #1;
    end
    bus.din_valid   = 1'b0;
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.frame_valid !== 1'b0 || bus.din_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b/%b exp=0/1", bus.frame_valid, bus.din_ready); end
    total++; if (bus.rem3 !== 2'd2) begin bad++; $display("FAIL bp_rem3 got=%0d exp=2", bus.rem3); end
  endtask

  task automatic test_invalid();
    drive_digit(4'd1, 1'b0);
    drive_digit(4'd2, 1'b0);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL inv_pre_err got=%b exp=0", bus.err); end
    drive_digit(4'hA, 1'b0);
    $display("invalid digit offered, err=%b", bus.err);
    total++; if (bus.err !== 1'b1 || bus.frame_valid !== 1'b0) begin bad++; $display("FAIL inv_err got=%b/%b exp=1/0", bus.err, bus.frame_valid); end
    @(posedge clk); #1;
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL inv_err_pulse got=%b exp=0", bus.err); end
    drive_frame(16'h8382, 1'b1);
    total++; if (bus.a !== 16'h8382 || bus.div_11_n3 !== 1'b1) begin bad++; $display("FAIL inv_next_frame got=%h/%b exp=8382/1", bus.a, bus.div_11_n3); end
    total++; if (bus.rem11 !== 4'd0 || bus.pred !== 1'b1) begin bad++; $display("FAIL inv_next_rem got=%0d/%b exp=0/1", bus.rem11, bus.pred); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    logic exp_err;
    drive_digit(4'd4, 1'b0);
    drive_digit(4'd5, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      exp_err = (k == 8);
      total++; if (bus.err !== exp_err) begin bad++; $display("FAIL to_err[%0d] got=%b exp=%b", k, bus.err, exp_err); end
    end
    drive_digit(4'd6, 1'b0);
    drive_digit(4'd7, 1'b0);
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL to_discard got=%b exp=0", bus.frame_valid); end
    drive_digit(4'd1, 1'b0);
    drive_digit(4'd2, 1'b0);
    $display("frame after timeout a=%h", bus.a);
    total++; if (bus.a !== 16'h6712 || bus.rem11 !== 4'd2 || bus.rem3 !== 2'd1) begin bad++; $display("FAIL to_fresh got=%h/%0d/%0d exp=6712/2/1", bus.a, bus.rem11, bus.rem3); end
    @(posedge clk); #1;
    drive_digit(4'd4, 1'b0);
    drive_digit(4'd5, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL nto_err[%0d] got=%b exp=0", k, bus.err); end
    end
    drive_digit(4'd6, 1'b0);
    drive_digit(4'd7, 1'b0);
    $display("frame after 7 idle a=%h", bus.a);
    total++; if (bus.a !== 16'h4567 || bus.frame_valid !== 1'b1) begin bad++; $display("FAIL nto_frame got=%h/%b exp=4567/1", bus.a, bus.frame_valid); end
    total++; if (bus.rem11 !== 4'd2 || bus.rem3 !== 2'd1 || bus.pred !== 1'b0) begin bad++; $display("FAIL nto_rem got=%0d/%0d/%b exp=2/1/0", bus.rem11, bus.rem3, bus.pred); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    drive_digit(4'd1, 1'b0);
    drive_digit(4'd2, 1'b0);
    bus.clear     = 1'b1;
    bus.din       = 4'd5;
    bus.din_valid = 1'b1;
    #1;
    total++; if (bus.din_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b exp=0", bus.din_ready); end
    @(posedge clk); #1;
    bus.clear     = 1'b0;
    bus.din_valid = 1'b0;
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", bus.err); end
    drive_frame(16'h7777, 1'b0);
    total++; if (bus.a !== 16'h7777 || bus.rem3 !== 2'd1) begin bad++; $display("FAIL clr_next got=%h/%0d exp=7777/1", bus.a, bus.rem3); end
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
    drive_frame(16'h1111, 1'b0);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL clrf_fv_pre got=%b exp=1", bus.frame_valid); end
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    total++; if (bus.frame_valid !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL clrf_drop got=%b/%b exp=0/0", bus.frame_valid, bus.err); end
    bus.frame_ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    drive_digit(4'd2, 1'b0);
    drive_digit(4'd3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.a !== 16'h0000 || bus.rem3 !== 2'd0 || bus.rem11 !== 4'd0) begin bad++; $display("FAIL rmid_out got=%h/%0d/%0d exp=0000/0/0", bus.a, bus.rem3, bus.rem11); end
    total++; if (bus.din_ready !== 1'b0 || bus.frame_valid !== 1'b0) begin bad++; $display("FAIL rmid_ctl got=%b/%b exp=0/0", bus.din_ready, bus.frame_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    drive_frame(16'h5678, 1'b0);
    total++; if (bus.a !== 16'h5678 || bus.rem3 !== 2'd2 || bus.rem11 !== 4'd2) begin bad++; $display("FAIL rmid_fresh got=%h/%0d/%0d exp=5678/2/2", bus.a, bus.rem3, bus.rem11); end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    bus.din         = 4'd0;
    bus.din_valid   = 1'b0;
    bus.mode_in     = 1'b0;
    bus.clear       = 1'b0;
    bus.frame_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_remainders();
    test_backpressure();
    test_invalid();
    test_timeout();
    test_clear();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_frame_loader.md
# bcd_frame_loader

Upstream stage for the combinational 4-digit BCD divisibility checker (`Main`). Accepts BCD digits one at a time, most significant first, over a valid/ready handshake, and assembles them into a 16-bit frame plus a mode bit. Presents the frame to the checker under a valid/ready handshake. Also computes running remainders mod 3 and mod 11 and a predicted checker result, so the checker's `o` can be cross-checked in-system.

## Interface
- `TIMEOUT`, default 255: idle cycles allowed between digits of a partial frame before the frame is aborted; 0 disables the timeout. Width 8 bits.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `din` in 4: BCD digit.
- `din_valid` in 1: `din` is offered.
- `din_ready` out 1: loader accepts a digit this cycle.
- `mode_in` in 1: 1 = divisible-by-11, 0 = divisible-by-3. Sampled with the first digit of a frame.
- `clear` in 1: synchronous abort.
- `a` out 16: frame.
  - `a[15:12]` is the thousands digit, so `a[15:12]`→`a30..a33`.
  - `a[3:0]` is the units digit, so `a[3:0]`→`a00..a03`.
- `div_11_n3` out 1: mode of the presented frame.
- `frame_valid` out 1: `a` and `div_11_n3` hold a complete frame.
- `frame_ready` in 1: downstream consumes the frame.
- `rem3` out 2: frame value mod 3.
- `rem11` out 4: frame value mod 11, range 0..10.
- `pred` out 1: `div_11_n3 ? (rem11==0) : (rem3==0)`.
- `err` out 1: one-cycle pulse on frame abort caused by an invalid digit or a timeout.

## Operation
- States:
  - IDLE: 0 digits held.
  - COLLECT: 1–3 digits held.
  - FULL: `frame_valid`=1.
- `din_ready` = 1 in IDLE and COLLECT when `clear`=0. It is 0 in FULL, including the FULL handshake cycle; there is no bypass.
- Transfer occurs when `din_valid && din_ready`. Digits shift into an internal register. Outputs `a`, `div_11_n3`, `rem3`, `rem11` and `pred` update only when a frame completes, and hold stable otherwise.
- Running remainders, per accepted digit d:
  - `r3 ← (r3 + d) mod 3`.
  - `r11 ← (d − r11) mod 11`, because 10 ≡ −1 (mod 11).
  - Both reset to 0 at the start of each frame.
- IDLE→COLLECT on first transfer; `mode_in` is latched.
- COLLECT→FULL on the 4th transfer.
- FULL→IDLE on the edge where `frame_ready`=1.
- Invalid digit (`din` > 9): the digit is consumed, the partial frame is discarded, the state goes to IDLE and `err` pulses. This applies in IDLE or COLLECT.
- Timeout (COLLECT only, `TIMEOUT`≠0):
  - Last accepted digit on edge E0.
  - No transfer on edges E1..E_TIMEOUT → state goes to IDLE on edge E_TIMEOUT, and `err` is high the following cycle.
  - The counter clears on every transfer.
- `clear`, highest priority:
  - Next state is IDLE; `frame_valid` drops on the next edge; the partial frame is discarded; `err` stays 0.
  - A digit offered during `clear` is not accepted.
- Simultaneous invalid digit and timeout edge: treated as a single abort, one `err` pulse.
- Reset values:
  - State IDLE.
  - `a`=0, `div_11_n3`=0, `frame_valid`=0, `rem3`=0, `rem11`=0, `pred`=0, `err`=0.
  - `din_ready`=0 while `rst`=1, and 1 from the first cycle after release.
- Reset mid-frame or in FULL: everything returns to reset values immediately (asynchronous).

## Timing
- All outputs are registered except `din_ready`, which decodes from the state and `clear` only.
- Latency: `frame_valid`, `a` and `rem*`/`pred` become valid in the cycle after the edge accepting the 4th digit.
- Minimum frame period: 5 cycles (4 transfers + 1 FULL cycle with `frame_ready`=1).
- `frame_valid` stays high with all frame outputs constant until the `frame_ready` handshake edge.
- `err` is a single-cycle pulse, registered, one cycle after the abort edge.

## Test plan
- Digits 3,2,3,4 with `mode_in`=0, back-to-back, `frame_ready`=1 → `a`=16'h3234, `div_11_n3`=0, `rem3`=0, `rem11`=0, `pred`=1. `frame_valid` is high exactly 1 cycle, on cycle 5.
- Digits 3,2,3,5 with `mode_in`=1, then 9,8,9,9 with `mode_in`=0:
  - First frame: `a`=16'h3235, `rem11`=1, `pred`=0.
  - Second frame: `a`=16'h9899, `rem3`=2, `rem11`=10, `pred`=0.
  - Digits 9,9,9,9 and 0,0,0,0 in either mode → `pred`=1.
- Backpressure: complete 8,5,5,8 with `frame_ready`=0 for 6 cycles → `frame_valid`=1 and `a`=16'h8558 are stable and `din_ready`=0 throughout. `frame_ready`=1 → IDLE next cycle.
- Invalid digit: 1,2,4'hA → `err` pulses once, state IDLE. Then 8,3,8,2 with `mode_in`=1 → clean frame 16'h8382, `rem11`=0, `pred`=1.
- Timeout with `TIMEOUT`=8: digits 4,5 then 8 idle cycles → `err` pulses at cycle 9 after the last digit. At 7 idle cycles followed by a digit → no abort.
- Control aborts:
  - `clear` in COLLECT → no `err`, next frame clean.
  - `clear` in FULL → `frame_valid` drops next cycle.
  - `rst` asserted mid-frame → all outputs 0 immediately, next 4 digits form a fresh frame.
